ssd_scan_reader: RTL and testbench



---
 rtl/ssd_scan_reader.sv | 156 +++++++++++++++
 tb/tb_ssd_scan_reader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_reader.sv
// Recovers hex nibbles from a multiplexed active-low seven-segment bus and
// presents each completed frame of digits on a valid/ready interface.
module ssd_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    state_t                  state;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_prev;
    logic [6:0]              seg_q;
    logic [6:0]              seg_prev;
    logic [7:0]              cnt;
    logic                    captured;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] stage_data;
    logic [NUM_DIGITS-1:0]   stage_err;

    int unsigned             low_cnt;
    logic                    legal;
    logic                    same;
    logic [7:0]              cnt_next;
    logic                    capture;
    logic                    complete;
    logic [4:0]              dec;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic [4*NUM_DIGITS-1:0] stage_data_next;
    logic [NUM_DIGITS-1:0]   stage_err_next;

    // Returns {err, nibble} for an active-high lit pattern.
    function automatic logic [4:0] decode(input logic [6:0] lit);
        case (lit)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        low_cnt = 0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) low_cnt = low_cnt + 1;
        end
        legal = (low_cnt == 1);
        same  = (an_q == an_prev) && (seg_q == seg_prev);

        if (!legal)
            cnt_next = '0;
        else if (same)
            cnt_next = (cnt == STABLE) ? cnt : cnt + 8'd1;
        else
            cnt_next = 8'd1;

        capture = legal && !captured && (cnt_next == STABLE);
        dec     = decode(~seg_q);

        stage_data_next = stage_data;
        stage_err_next  = stage_err;
        seen_next       = seen;
        if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (!an_q[i]) begin
                    stage_data_next[4*i +: 4] = dec[3:0];
                    stage_err_next[i]         = dec[4];
                    seen_next[i]              = 1'b1;
                end
            end
        end
        complete = capture && (&seen_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            an_q        <= '1;
            an_prev     <= '1;
            seg_q       <= '1;
            seg_prev    <= '1;
            cnt         <= '0;
            captured    <= 1'b0;
            seen        <= '0;
            stage_data  <= '0;
            stage_err   <= '0;
            frame_data  <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            an_q       <= an_n;
            seg_q      <= seg_n;
            an_prev    <= an_q;
            seg_prev   <= seg_q;
            cnt        <= cnt_next;
            captured   <= (legal && same) ? (captured | capture) : 1'b0;
            stage_data <= stage_data_next;
            stage_err  <= stage_err_next;
            seen       <= complete ? '0 : seen_next;

            // Outputs load from the next-staging values so a capture that
            // completes the frame lands in the same cycle.
            case (state)
                IDLE: begin
                    if (complete) begin
                        frame_data  <= stage_data_next;
                        frame_err   <= stage_err_next;
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        if (complete) begin
                            frame_data <= stage_data_next;
                            frame_err  <= stage_err_next;
                        end else begin
                            frame_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (complete) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Directed bench for ssd_scan_reader: scans digit patterns onto the bus and
// checks recovered frames, handshake behaviour, overrun and reset handling.
module tb_ssd_scan_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [15:0] frame_data;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int acc_cnt   = 0;
    logic [15:0] acc_data = '0;
    logic [3:0]  acc_err  = '0;

    localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    ssd_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_data (frame_data),
        .frame_err  (frame_err),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun    (overrun)
    );

    // Inputs change 2ns after a rising edge; accepted frames are logged mid-cycle.
    always @(negedge clk) begin
        if (!reset && frame_valid && frame_ready) begin
            acc_cnt  = acc_cnt + 1;
            acc_data = frame_data;
            acc_err  = frame_err;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic show(input int d, input logic [6:0] lit, input int n);
        an_n  = ~(4'b0001 << d);
        seg_n = ~lit;
        step(n);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        an_n  = '1;
        seg_n = '1;
        step(3);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        an_n  = '1;
        seg_n = '1;
        frame_ready = 1'b1;
        step(3);
        total_cnt++; if (frame_data !== 16'h0000) $display("FAIL reset_data: got %h expected %h", frame_data, 16'h0000); else pass_cnt++;
        total_cnt++; if (frame_err !== 4'h0) $display("FAIL reset_err: got %b expected %b", frame_err, 4'h0); else pass_cnt++;
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL reset_valid: got %b expected %b", frame_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected %b", overrun, 1'b0); else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_basic_scan;
        int c0, first_k, vcount;
        logic [15:0] snap;
        do_reset();
        frame_ready = 1'b1;
        c0 = acc_cnt;
        show(0, LIT[1], 10);
        show(1, LIT[2], 10);
        show(2, LIT[3], 10);
        an_n  = 4'b0111;
        seg_n = ~LIT[4];
        first_k = 0; vcount = 0; snap = '0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (frame_valid === 1'b1) begin
                vcount++;
                if (first_k == 0) begin first_k = k; snap = frame_data; end
            end
        end
        total_cnt++; if (first_k != 9) $display("FAIL basic_latency: got %0d expected %0d", first_k, 9); else pass_cnt++;
        total_cnt++; if (vcount != 1) $display("FAIL basic_pulse_width: got %0d expected %0d", vcount, 1); else pass_cnt++;
        total_cnt++; if (snap !== 16'h4321) $display("FAIL basic_data: got %h expected %h", snap, 16'h4321); else pass_cnt++;
        total_cnt++; if (acc_cnt != c0 + 1) $display("FAIL basic_count: got %0d expected %0d", acc_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (acc_err !== 4'h0) $display("FAIL basic_err: got %b expected %b", acc_err, 4'h0); else pass_cnt++;
    endtask

    task automatic test_short_dwell;
        int c0;
        do_reset();
        frame_ready = 1'b1;
        c0 = acc_cnt;
        show(0, LIT[10], 10);
        show(1, LIT[11], 10);
        show(2, LIT[12], 5);
        show(3, LIT[13], 10);
        total_cnt++; if (acc_cnt != c0) $display("FAIL short_no_frame: got %0d expected %0d", acc_cnt - c0, 0); else pass_cnt++;
        // Digit 3 is already seen, so the frame completes on digit 2 of this scan.
        show(0, LIT[10], 10);
        show(1, LIT[11], 10);
        show(2, LIT[12], 10);
        show(3, LIT[13], 10);
        total_cnt++; if (acc_cnt != c0 + 1) $display("FAIL short_count: got %0d expected %0d", acc_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (acc_data !== 16'hDCBA) $display("FAIL short_data: got %h expected %h", acc_data, 16'hDCBA); else pass_cnt++;
        total_cnt++; if (acc_err !== 4'h0) $display("FAIL short_err: got %b expected %b", acc_err, 4'h0); else pass_cnt++;
    endtask

    task automatic test_blank;
        int c0;
        do_reset();
        frame_ready = 1'b1;
        c0 = acc_cnt;
        show(0, LIT[1], 10);
        show(1, 7'h00, 10);
        show(2, LIT[3], 10);
        show(3, LIT[4], 10);
        total_cnt++; if (acc_cnt != c0 + 1) $display("FAIL blank_count: got %0d expected %0d", acc_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (acc_data !== 16'h4301) $display("FAIL blank_data: got %h expected %h", acc_data, 16'h4301); else pass_cnt++;
        total_cnt++; if (acc_err !== 4'b0010) $display("FAIL blank_err: got %b expected %b", acc_err, 4'b0010); else pass_cnt++;
    endtask

    task automatic test_illegal;
        int c0;
        do_reset();
        frame_ready = 1'b1;
        c0 = acc_cnt;
        show(0, LIT[5], 10);
        show(1, LIT[6], 10);
        an_n  = 4'b1010;
        seg_n = ~LIT[7];
        step(20);
        total_cnt++; if (acc_cnt != c0) $display("FAIL illegal_no_frame: got %0d expected %0d", acc_cnt - c0, 0); else pass_cnt++;
        show(2, LIT[7], 10);
        show(3, LIT[8], 10);
        total_cnt++; if (acc_cnt != c0 + 1) $display("FAIL illegal_count: got %0d expected %0d", acc_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (acc_data !== 16'h8765) $display("FAIL illegal_data: got %h expected %h", acc_data, 16'h8765); else pass_cnt++;
    endtask

    task automatic test_overrun;
        int low_cycles;
        logic [15:0] snap;
        do_reset();
        frame_ready = 1'b0;
        show(0, LIT[1], 10); show(1, LIT[2], 10); show(2, LIT[3], 10); show(3, LIT[4], 10);
        total_cnt++; if (frame_valid !== 1'b1) $display("FAIL ovr_hold_valid: got %b expected %b", frame_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_first_overrun: got %b expected %b", overrun, 1'b0); else pass_cnt++;
        show(0, LIT[5], 10); show(1, LIT[6], 10); show(2, LIT[7], 10); show(3, LIT[8], 10);
        total_cnt++; if (frame_valid !== 1'b1) $display("FAIL ovr_drop_valid: got %b expected %b", frame_valid, 1'b1); else pass_cnt++;
        total_cnt++; if (frame_data !== 16'h4321) $display("FAIL ovr_drop_data: got %h expected %h", frame_data, 16'h4321); else pass_cnt++;
        total_cnt++; if (frame_err !== 4'h0) $display("FAIL ovr_drop_err: got %b expected %b", frame_err, 4'h0); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected %b", overrun, 1'b1); else pass_cnt++;
        show(0, LIT[9], 10); show(1, LIT[10], 10); show(2, LIT[11], 10);
        an_n  = 4'b0111;
        seg_n = ~LIT[12];
        low_cycles = 0; snap = '0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (frame_valid !== 1'b1) low_cycles++;
            if (k == 9) snap = frame_data;
            frame_ready = (k == 8);
        end
        total_cnt++; if (low_cycles != 0) $display("FAIL ovr_valid_stays: got %0d low cycles expected %0d", low_cycles, 0); else pass_cnt++;
        total_cnt++; if (snap !== 16'hCBA9) $display("FAIL ovr_reload_data: got %h expected %h", snap, 16'hCBA9); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected %b", overrun, 1'b1); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int c0;
        frame_ready = 1'b0;
        show(0, LIT[1], 10);
        show(1, LIT[2], 10);
        show(2, LIT[3], 4);
        reset = 1'b1;
        step(2);
        total_cnt++; if (frame_data !== 16'h0000) $display("FAIL mid_reset_data: got %h expected %h", frame_data, 16'h0000); else pass_cnt++;
        total_cnt++; if (frame_err !== 4'h0) $display("FAIL mid_reset_err: got %b expected %b", frame_err, 4'h0); else pass_cnt++;
        total_cnt++; if (frame_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected %b", frame_valid, 1'b0); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL mid_reset_overrun: got %b expected %b", overrun, 1'b0); else pass_cnt++;
        reset = 1'b0;
        frame_ready = 1'b1;
        c0 = acc_cnt;
        show(0, LIT[14], 10); show(1, LIT[15], 10); show(2, LIT[0], 10); show(3, LIT[1], 10);
        total_cnt++; if (acc_cnt != c0 + 1) $display("FAIL mid_after_count: got %0d expected %0d", acc_cnt - c0, 1); else pass_cnt++;
        total_cnt++; if (acc_data !== 16'h10FE) $display("FAIL mid_after_data: got %h expected %h", acc_data, 16'h10FE); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL mid_after_overrun: got %b expected %b", overrun, 1'b0); else pass_cnt++;
    endtask

    initial begin
        reset       = 1'b1;
        an_n        = '1;
        seg_n       = '1;
        frame_ready = 1'b1;
        test_reset();
        test_basic_scan();
        test_short_dwell();
        test_blank();
        test_illegal();
        test_overrun();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
